// File: rtl/sigmoid_pkg.sv
// -----------------------------------------------------------------------------
// sigmoid_pkg
//
// Shared types and constants for the sigmoid output scorer.
//   state_t      : scorer FSM states
//   YW           : default sample width of the sigmoid output stream
//   SSE_W        : width of the squared-error accumulator
//   CYC_W        : width of the execution-cycle counter
//   COUNT_W      : width of the accepted-sample counter
//   SCORE_SHIFT  : the score is the accumulator with this many LSBs dropped
// -----------------------------------------------------------------------------
package sigmoid_pkg;

    typedef enum logic [2:0] {
        IDLE,    // waiting for a start pulse
        RUN,     // goldens accepted, waiting for the first output sample
        STREAM,  // one output sample consumed per cycle
        DRAIN,   // arithmetic pipeline empties
        DONE,    // final results held
        ERR      // protocol violation, results frozen
    } state_t;

    localparam int YW          = 16;
    localparam int SSE_W       = 48;
    localparam int CYC_W       = 32;
    localparam int COUNT_W     = 9;
    localparam int SCORE_SHIFT = 8;
    localparam int SCORE_W     = SSE_W - SCORE_SHIFT;

endpackage : sigmoid_pkg

// File: rtl/scorer_fifo.sv
// -----------------------------------------------------------------------------
// scorer_fifo
//
// Synchronous FIFO that buffers golden reference values until the matching
// sigmoid output arrives. The occupancy count is kept in its own register so
// full and empty are never ambiguous when the pointers are equal. The head
// entry is presented combinationally on dout; a value written in one cycle is
// only visible at the head from the next cycle (there is no write-through).
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of pointers and count (wins over push/pop)
//   push, din  : write request and data, ignored while full
//   pop        : read request, advances the head, ignored while empty
//   dout       : current head entry
//   full/empty : decoded from the registered count
// -----------------------------------------------------------------------------
module scorer_fifo #(
    parameter int DEPTH = 16,
    parameter int YW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [YW-1:0] din,
    input  logic          pop,
    output logic [YW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [YW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only read after being
    // written, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule : scorer_fifo

// File: rtl/sigmoid_scorer.sv
// -----------------------------------------------------------------------------
// sigmoid_scorer
//
// On-chip scorer for the sigmoid unit. Golden values are pushed into a small
// FIFO ahead of time; each sigmoid output sample pops one golden and the
// squared difference is accumulated through a two-stage pipeline:
//   stage 1 : d = |y - g|            (registered, YW bits)
//   stage 2 : sse += d*d             (2*YW-bit product, zero-extended)
// The block also counts execution cycles from start to the last sample and
// traps protocol violations (sample with no golden buffered, or the valid run
// breaking before PATTERN samples).
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_start           : one-cycle pulse, clears everything and enters RUN
//   i_gol_valid/i_gol : golden push, taken when o_gol_ready is high
//   o_gol_ready       : FIFO not full and block in RUN/STREAM/DRAIN
//   i_y_valid/i_y     : sigmoid output stream
//   o_done            : run completed, results final
//   o_err             : sticky protocol-violation flag
//   o_count           : samples consumed so far
//   o_cycles          : cycles spent in RUN/STREAM up to the last sample
//   o_sse             : sum of squared errors
//   o_score           : o_sse with the low SCORE_SHIFT bits dropped
// -----------------------------------------------------------------------------
module sigmoid_scorer
    import sigmoid_pkg::*;
#(
    parameter int PATTERN = 256,
    parameter int DEPTH   = 16,
    parameter int YW      = sigmoid_pkg::YW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_gol_valid,
    input  logic [YW-1:0]      i_gol,
    output logic               o_gol_ready,
    input  logic               i_y_valid,
    input  logic [YW-1:0]      i_y,
    output logic               o_done,
    output logic               o_err,
    output logic [COUNT_W-1:0] o_count,
    output logic [CYC_W-1:0]   o_cycles,
    output logic [SSE_W-1:0]   o_sse,
    output logic [SCORE_W-1:0] o_score
);

    localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(PATTERN - 1);

    state_t          state;
    logic            drain_cnt;

    // Golden FIFO interface.
    logic            fifo_full;
    logic            fifo_empty;
    logic [YW-1:0]   gol_head;
    logic            gol_push;

    // Per-cycle decisions.
    logic            consume;
    logic            violation;
    logic            last_sample;

    // Arithmetic pipeline.
    logic            s1_valid;
    logic [YW-1:0]   s1_d;
    logic [YW-1:0]   abs_diff;
    logic [2*YW-1:0] s1_d_wide;
    logic [2*YW-1:0] sq;

    // -------------------------------------------------------------------------
    // Golden buffer
    // -------------------------------------------------------------------------
    // Ready is derived only from registered state and count, so a pop in the
    // same cycle never makes room for a push into a full FIFO.
    assign o_gol_ready = !fifo_full &&
                         (state == RUN || state == STREAM || state == DRAIN);
    assign gol_push    = i_gol_valid && o_gol_ready;

    scorer_fifo #(
        .DEPTH (DEPTH),
        .YW    (YW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (i_start),
        .push  (gol_push),
        .din   (i_gol),
        .pop   (consume),
        .dout  (gol_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // -------------------------------------------------------------------------
    // Sample acceptance and protocol checking
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        consume   = 1'b0;
        violation = 1'b0;
        // A start pulse overrides whatever the stream is doing this cycle.
        if (!i_start && (state == RUN || state == STREAM)) begin
            if (i_y_valid) begin
                if (fifo_empty) violation = 1'b1;
                else            consume   = 1'b1;
            end else if (state == STREAM) begin
                // Once the stream has begun, valid must stay high.
                violation = 1'b1;
            end
        end
    end

    assign last_sample = consume && (o_count == LAST_IDX);

    // -------------------------------------------------------------------------
    // FSM, sample counter and cycle counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_count   <= '0;
            o_cycles  <= '0;
        end else if (i_start) begin
            state     <= RUN;
            drain_cnt <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_count   <= '0;
            o_cycles  <= '0;
        end else begin
            case (state)
                RUN, STREAM: begin
                    if (violation) begin
                        // Counters stay at their last good values.
                        state <= ERR;
                        o_err <= 1'b1;
                    end else begin
                        o_cycles <= o_cycles + 1'b1;
                        if (consume) begin
                            o_count <= o_count + 1'b1;
                            if (last_sample) begin
                                state     <= DRAIN;
                                drain_cnt <= 1'b0;
                            end else begin
                                state <= STREAM;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // Two cycles: one for stage 1 to hand off, one for the
                    // final accumulate.
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
                default: ;  // IDLE, DONE, ERR wait for i_start
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Abs-diff / square-accumulate datapath
    // -------------------------------------------------------------------------
    assign abs_diff  = (i_y >= gol_head) ? (i_y - gol_head) : (gol_head - i_y);
    assign s1_d_wide = {{YW{1'b0}}, s1_d};
    assign sq        = s1_d_wide * s1_d_wide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_d     <= '0;
            o_sse    <= '0;
        end else if (i_start) begin
            s1_valid <= 1'b0;
            s1_d     <= '0;
            o_sse    <= '0;
        end else begin
            s1_valid <= consume;
            if (consume) begin
                s1_d <= abs_diff;
            end
            // A sample already consumed before a violation is still scored.
            if (s1_valid) begin
                o_sse <= o_sse + SSE_W'(sq);
            end
        end
    end

    assign o_score = o_sse[SSE_W-1:SCORE_SHIFT];

endmodule : sigmoid_scorer

// File: tb/tb_sigmoid_scorer.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_scorer
//
// Directed sequence of scoring runs with randomized golden/sample data. The
// expected sum of squared errors, sample count and cycle count are computed
// from the data arrays with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_sigmoid_scorer;

    localparam int PATTERN = 256;
    localparam int DEPTH   = 16;
    localparam int YW      = 16;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic          i_gol_valid;
    logic [YW-1:0] i_gol;
    logic          o_gol_ready;
    logic          i_y_valid;
    logic [YW-1:0] i_y;
    logic          o_done;
    logic          o_err;
    logic [8:0]    o_count;
    logic [31:0]   o_cycles;
    logic [47:0]   o_sse;
    logic [39:0]   o_score;

    int n_checks = 0;
    int n_errors = 0;

    logic [YW-1:0] gol [PATTERN];
    logic [YW-1:0] yv  [PATTERN];

    sigmoid_scorer #(
        .PATTERN (PATTERN),
        .DEPTH   (DEPTH),
        .YW      (YW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_gol_valid (i_gol_valid),
        .i_gol       (i_gol),
        .o_gol_ready (o_gol_ready),
        .i_y_valid   (i_y_valid),
        .i_y         (i_y),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_count     (o_count),
        .o_cycles    (o_cycles),
        .o_sse       (o_sse),
        .o_score     (o_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    // Reference: sum of (y - g)^2 over the first n samples.
    function automatic longint model_sse(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) begin
            longint d = longint'(yv[i]) - longint'(gol[i]);
            s += d * d;
        end
        return s;
    endfunction

    // Pushes goldens whenever the scorer is ready and, after `gap` idle RUN
    // cycles, streams n_y contiguous samples. With full_probe set, checks the
    // full-FIFO refusal at the first sample and the acceptance just after.
    task automatic run_stream(input string tag, input int gap, input int n_y, input bit full_probe);
        int  gi  = 0;
        int  yi  = 0;
        int  cyc = 0;
        int  budget = gap + 4 * PATTERN + 50;
        bit  push;
        while (yi < n_y) begin
            if (cyc > budget) begin
                n_checks++;
                n_errors++;
                $error("FAIL %s_timeout: observed %0d samples expected %0d", tag, yi, n_y);
                break;
            end
            i_gol_valid = (gi < PATTERN);
            i_gol       = (gi < PATTERN) ? gol[gi] : '0;
            push        = i_gol_valid && o_gol_ready;
            if (full_probe && cyc == gap) begin
                check({tag, "_accepted_until_full"}, 64'(gi), 64'(DEPTH));
                check({tag, "_ready_when_full"}, 64'(o_gol_ready), 64'(0));
            end
            if (full_probe && cyc == gap + 1) begin
                check({tag, "_ready_after_pop"}, 64'(o_gol_ready), 64'(1));
            end
            i_y_valid = (cyc >= gap);
            i_y       = yv[yi];
            step();
            if (push)      gi++;
            if (i_y_valid) yi++;
            cyc++;
        end
        i_y_valid   = 1'b0;
        i_gol_valid = 1'b0;
    endtask

    // Called right after the last sample edge: done must rise exactly two
    // cycles later with all results final.
    task automatic check_done(input string tag, input int gap, input longint exp_sse);
        check({tag, "_done_l0"}, 64'(o_done), 64'(0));
        step();
        check({tag, "_done_l1"}, 64'(o_done), 64'(0));
        step();
        check({tag, "_done"},   64'(o_done),   64'(1));
        check({tag, "_err"},    64'(o_err),    64'(0));
        check({tag, "_count"},  64'(o_count),  64'(PATTERN));
        check({tag, "_sse"},    64'(o_sse),    64'(exp_sse));
        check({tag, "_score"},  64'(o_score),  64'(exp_sse >> 8));
        check({tag, "_cycles"}, 64'(o_cycles), 64'(gap + PATTERN));
        check({tag, "_ready"},  64'(o_gol_ready), 64'(0));
    endtask

    initial begin
        int gap;

        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_gol_valid = 1'b0;
        i_gol       = '0;
        i_y_valid   = 1'b0;
        i_y         = '0;

        // ---- reset state ----
        repeat (3) step();
        check("rst_done",   64'(o_done),      64'(0));
        check("rst_err",    64'(o_err),       64'(0));
        check("rst_ready",  64'(o_gol_ready), 64'(0));
        check("rst_count",  64'(o_count),     64'(0));
        check("rst_cycles", 64'(o_cycles),    64'(0));
        check("rst_sse",    64'(o_sse),       64'(0));
        rst_n = 1'b1;
        step();
        // Samples in IDLE are ignored.
        i_y_valid = 1'b1;
        step();
        i_y_valid = 1'b0;
        check("idle_err",   64'(o_err),   64'(0));
        check("idle_count", 64'(o_count), 64'(0));

        // ---- A: golden 0..255, y == g, first sample after 10 RUN cycles ----
        for (int i = 0; i < PATTERN; i++) begin
            gol[i] = YW'(i);
            yv[i]  = YW'(i);
        end
        pulse_start();
        run_stream("exact", 10, PATTERN, 1'b0);
        check_done("exact", 10, 0);

        // ---- B: y = g + 3 everywhere ----
        for (int i = 0; i < PATTERN; i++) begin
            gol[i] = YW'($urandom_range(0, 65000));
            yv[i]  = gol[i] + YW'(3);
        end
        gap = $urandom_range(1, 16);
        pulse_start();
        run_stream("plus3", gap, PATTERN, 1'b0);
        check_done("plus3", gap, 2304);
        check("plus3_score9", 64'(o_score), 64'(9));

        // ---- C: fully random data and gap ----
        for (int i = 0; i < PATTERN; i++) begin
            gol[i] = YW'($urandom());
            yv[i]  = YW'($urandom());
        end
        gap = $urandom_range(1, 30);
        pulse_start();
        run_stream("rand", gap, PATTERN, 1'b0);
        check_done("rand", gap, model_sse(PATTERN));

        // ---- F: fill the FIFO, refused push during pop, wrap-around order ----
        for (int i = 0; i < PATTERN; i++) begin
            gol[i] = YW'($urandom());
            yv[i]  = gol[i];
        end
        pulse_start();
        run_stream("wrap", 20, PATTERN, 1'b1);
        check_done("wrap", 20, 0);

        // ---- D: valid drops after sample 100 ----
        for (int i = 0; i < PATTERN; i++) begin
            gol[i] = YW'($urandom());
            yv[i]  = YW'($urandom());
        end
        pulse_start();
        run_stream("drop", 4, 101, 1'b0);
        check("drop_err_before", 64'(o_err),   64'(0));
        check("drop_count_pre",  64'(o_count), 64'(101));
        step();
        check("drop_err",   64'(o_err),  64'(1));
        check("drop_done",  64'(o_done), 64'(0));
        repeat (3) step();
        check("drop_count_frozen", 64'(o_count),     64'(101));
        check("drop_ready",        64'(o_gol_ready), 64'(0));
        pulse_start();
        check("clear_err",    64'(o_err),    64'(0));
        check("clear_count",  64'(o_count),  64'(0));
        check("clear_sse",    64'(o_sse),    64'(0));
        check("clear_cycles", 64'(o_cycles), 64'(0));

        // ---- E: sample with no golden buffered ----
        i_y_valid = 1'b1;
        step();
        i_y_valid = 1'b0;
        check("underflow_err",   64'(o_err),   64'(1));
        check("underflow_count", 64'(o_count), 64'(0));

        // ---- start coincident with a valid sample: start wins ----
        pulse_start();
        run_stream("coinc", 3, 5, 1'b0);
        check("coinc_count_pre", 64'(o_count), 64'(5));
        i_start   = 1'b1;
        i_y_valid = 1'b1;
        step();
        i_start   = 1'b0;
        i_y_valid = 1'b0;
        check("coinc_count", 64'(o_count), 64'(0));
        check("coinc_err",   64'(o_err),   64'(0));
        step();
        check("coinc_run_idle_err", 64'(o_err), 64'(0));

        // ---- asynchronous reset mid-run ----
        pulse_start();
        run_stream("arst", 3, 50, 1'b0);
        i_y_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        i_y_valid = 1'b0;
        check("arst_count", 64'(o_count),     64'(0));
        check("arst_sse",   64'(o_sse),       64'(0));
        check("arst_ready", 64'(o_gol_ready), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        check("arst_idle_ready", 64'(o_gol_ready), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sigmoid_scorer
